pipe_reg_elastic: RTL and testbench
===================================

# pipe_reg_elastic

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the fixed-width, single-entry, stall-vector-driven stage registers with a DEPTH-entry FIFO that uses a valid/ready handshake. The FIFO presents a configurable NOP word to the downstream stage whenever it is empty. It also supports a synchronous flush for branch/exception squash and keeps saturating bubble and stall counters for pipeline profiling.

## Interface
- DW, 32: payload width in bits. The upstream stage packs aluop, alusel, operands, we, waddr, slot and link fields into this word.
- DEPTH, 2: number of entries, legal range 1..4. DEPTH=1 gives a classic single stage register.
- NOP_WORD, {DW{1'b0}}: payload driven on out_data when no valid entry is present.
- STAT_W, 16: width of each profiling counter.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash: discards all entries.
- stat_clr  in  1  synchronous clear of both counters.
- in_valid  in  1  upstream presents a payload.
- in_data  in  DW  upstream payload.
- in_ready  out  1  buffer can accept a payload this cycle.
- out_valid  out  1  out_data holds a real entry.
- out_data  out  DW  head entry, or NOP_WORD when empty.
- out_ready  in  1  downstream consumes the head this cycle.
- occupancy  out  $clog2(DEPTH+1)  current number of entries.
- bubble_cnt  out  STAT_W  cycles in which the downstream received a NOP.
- stall_cnt  out  STAT_W  cycles in which upstream was back-pressured.

## Operation
- Storage: circular buffer of DEPTH entries, with a write pointer, a read pointer and a count.
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- in_ready = (count != DEPTH).
  - It is purely state-based, with no combinational path from out_ready.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid is high, otherwise NOP_WORD. It is a mux of registered state only.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- On a push, the entry is written at wr_ptr and wr_ptr advances.
- On a pop, rd_ptr advances.
- count changes by +1 on a push alone, by -1 on a pop alone, and is unchanged when both happen.
- Push and pop in the same cycle:
  - Allowed whenever 0 < count < DEPTH.
  - When full, in_ready is low, so there is no push even if a pop occurs. The freed slot becomes visible on the next cycle.
  - When empty, there is no pop, so pushed data never bypasses the register.
- flush has priority over everything else. On the next edge:
  - count = 0 and both pointers = 0.
  - Any same-cycle push is dropped and any same-cycle pop is ignored.
  - Entry contents are don't-care.
- bubble_cnt: increments when ~out_valid & out_ready & ~flush. Saturates at all-ones.
- stall_cnt: increments when in_valid & ~in_ready. Saturates at all-ones. It counts during flush cycles as well.
- stat_clr zeroes both counters on the next edge and overrides any increment in that cycle. flush does not affect the counters.
- occupancy = count.

## Timing
- Reset (async assert, released synchronously by the system) sets:
  - count, pointers, occupancy, bubble_cnt and stall_cnt = 0.
  - out_valid = 0, in_ready = 1 and out_data = NOP_WORD, all immediately on assertion.
- Latency: a payload accepted at edge N appears on out_data/out_valid after edge N, so the minimum latency is 1 cycle.
- Throughput is 1 entry/cycle whenever DEPTH ≥ 2 and the buffer is not full.
  - With DEPTH=1, a full entry blocks in_ready for the cycle it is popped, so sustained throughput is 1 entry per 2 cycles. The upstream stage accepts this cost when it instantiates DEPTH=1.
- Handshake rules:
  - Upstream holds in_data stable while in_valid is high and in_ready is low.
  - The downstream may sample out_data whenever out_valid is high.
  - out_data remains stable until the edge after a pop or flush.
- Reset asserted mid-transfer: all entries are lost, the in-flight push is dropped and the counters are cleared.

## Test plan
- DEPTH=2, DW=32:
  - Stimulus: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=0.
  - Required response: in_ready drops after the second push, occupancy=2, stall_cnt=1.
  - Then raise out_ready: out_data reads 0x11 then 0x22, and 0x33 is accepted the cycle after the first pop.
- Empty buffer with out_ready=1 for 5 cycles:
  - Required response: out_valid=0, out_data=NOP_WORD, bubble_cnt=5.
  - Then push 0xAB at edge N: out_data=0xAB with out_valid=1 after edge N, with no same-cycle bypass.
- Buffer full (0x01, 0x02), then flush=1 together with in_valid=1 carrying 0x03 and out_ready=1:
  - Required response on the next cycle: occupancy=0, out_valid=0, out_data=NOP_WORD, and 0x03 is not stored.
  - Counters are unchanged except stall_cnt, which increments by 1.
- DEPTH=3, wrap-around test:
  - Stimulus: stream 0x00..0x09 with out_ready toggling 1,0,1,0,… while upstream pushes whenever in_ready is high.
  - Required response: output order is exactly 0x00..0x09 with no loss or duplication. occupancy is never above 3, and in_ready is low whenever occupancy=3.
- Saturation with STAT_W=4: hold out_ready=1 while empty for 20 cycles.
  - Required response: bubble_cnt stays at 15.
  - stat_clr for 1 cycle → bubble_cnt=0 after that edge.
- Async reset asserted mid-cycle while occupancy=2:
  - Required response: outputs go to reset values immediately, without waiting for clk, and operation resumes normally after release.

Source files
------------

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH-entry elastic stage register with NOP-on-empty output, flush and profiling counters
// Ports: clk/rst (async, active-high); flush squashes all entries; stat_clr zeroes the counters;
//        in_valid/in_data/in_ready upstream handshake; out_valid/out_data/out_ready downstream handshake;
//        occupancy = entry count; bubble_cnt/stall_cnt saturating NOP-delivered / back-pressure cycle counts.
module pipe_reg_elastic #(
  parameter int DW = 32,
  parameter int DEPTH = 2,
  parameter logic [DW-1:0] NOP_WORD = '0,
  parameter int STAT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stat_clr,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [STAT_W-1:0]          bubble_cnt,
  output logic [STAT_W-1:0]          stall_cnt
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_cnt;
  logic [STAT_W-1:0] r_bub, r_stall;
  logic              w_push, w_pop, w_bub_inc, w_stall_inc;
  logic [PW-1:0]     w_wr_nxt, w_rd_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  always_comb begin
    in_ready    = r_cnt != CW'(DEPTH);
    out_valid   = r_cnt != '0;
    out_data    = out_valid ? r_mem[r_rd_ptr] : NOP_WORD;
    w_push      = in_valid & in_ready & ~flush;
    w_pop       = out_valid & out_ready & ~flush;
    w_bub_inc   = ~out_valid & out_ready & ~flush;
    w_stall_inc = in_valid & ~in_ready;
    // explicit wrap so non-power-of-two depths work
    w_wr_nxt    = r_wr_ptr == PW'(DEPTH-1) ? '0 : r_wr_ptr + PW'(1);
    w_rd_nxt    = r_rd_ptr == PW'(DEPTH-1) ? '0 : r_rd_ptr + PW'(1);
    w_cnt_nxt   = (w_push & ~w_pop) ? r_cnt + CW'(1) : (~w_push & w_pop) ? r_cnt - CW'(1) : r_cnt;
    occupancy   = r_cnt;
    bubble_cnt  = r_bub;
    stall_cnt   = r_stall;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_bub    <= '0;
      r_stall  <= '0;
    end else begin
      r_wr_ptr <= flush ? '0 : w_push ? w_wr_nxt : r_wr_ptr;
      r_rd_ptr <= flush ? '0 : w_pop ? w_rd_nxt : r_rd_ptr;
      r_cnt    <= flush ? '0 : w_cnt_nxt;
      r_bub    <= stat_clr ? '0 : (w_bub_inc && r_bub != '1) ? r_bub + STAT_W'(1) : r_bub;
      r_stall  <= stat_clr ? '0 : (w_stall_inc && r_stall != '1) ? r_stall + STAT_W'(1) : r_stall;
    end
  end
  // payload storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end
endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb_pipe_reg_elastic: scoreboard bench for pipe_reg_elastic (DEPTH=2 and DEPTH=3/STAT_W=4 instances)
module tb_pipe_reg_elastic;
  localparam logic [31:0] NOP0 = 32'hDEAD_BEEF;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv[2], fl[2], sc[2], ordy[2];
  logic [31:0] id[2];
  logic        rdy[2], ov[2];
  logic [31:0] od[2];
  logic [1:0]  occ[2];
  logic [15:0] bub0, stl0;
  logic [3:0]  bub1, stl1;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mq[2][$];
  int          mbub[2], mstl[2];
  int          dep[2] = '{2, 3};
  int          smax[2] = '{65535, 15};
  logic [31:0] nop[2] = '{NOP0, 32'h0};

  pipe_reg_elastic #(.DW(32), .DEPTH(2), .NOP_WORD(NOP0), .STAT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(fl[0]), .stat_clr(sc[0]), .in_valid(iv[0]), .in_data(id[0]),
    .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]),
    .occupancy(occ[0]), .bubble_cnt(bub0), .stall_cnt(stl0));
  pipe_reg_elastic #(.DW(32), .DEPTH(3), .NOP_WORD(32'h0), .STAT_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .stat_clr(sc[1]), .in_valid(iv[1]), .in_data(id[1]),
    .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]),
    .occupancy(occ[1]), .bubble_cnt(bub1), .stall_cnt(stl1));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // reference model: a plain queue bounded at DEPTH plus saturating integer counters
  initial begin
    int  sz;
    bit  full, emp, pu, po;
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          mq[k].delete();
          mbub[k] = 0;
          mstl[k] = 0;
        end else begin
          sz   = mq[k].size();
          full = sz == dep[k];
          emp  = sz == 0;
          pu   = iv[k] && !full && !fl[k];
          po   = !emp && ordy[k] && !fl[k];
          if (sc[k]) mbub[k] = 0;
          else if (emp && ordy[k] && !fl[k] && mbub[k] < smax[k]) mbub[k]++;
          if (sc[k]) mstl[k] = 0;
          else if (iv[k] && full && mstl[k] < smax[k]) mstl[k]++;
          if (fl[k]) mq[k].delete();
          else begin
            if (po) void'(mq[k].pop_front());
            if (pu) mq[k].push_back(id[k]);
          end
        end
      end
    end
  end

  // monitor: compares presented outputs against the model/scoreboard every falling edge
  initial begin
    int sz;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        sz = mq[k].size();
        check($sformatf("u%0d out_valid", k), 32'(ov[k]), 32'(sz != 0));
        check($sformatf("u%0d in_ready", k), 32'(rdy[k]), 32'(sz != dep[k]));
        check($sformatf("u%0d occupancy", k), 32'(occ[k]), 32'(sz));
        if (ov[k] && sz != 0) check($sformatf("u%0d head data", k), od[k], mq[k][0]);
        else check($sformatf("u%0d nop data", k), od[k], nop[k]);
        check($sformatf("u%0d bubble_cnt", k), k == 0 ? 32'(bub0) : 32'(bub1), 32'(mbub[k]));
        check($sformatf("u%0d stall_cnt", k), k == 0 ? 32'(stl0) : 32'(stl1), 32'(mstl[k]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int          nxt, b, s;
    int          got[$];
    bit          tog, acc;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; fl[k] = 0; sc[k] = 0; ordy[k] = 0; id[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(ov[0]), 0);
    check("rst in_ready", 32'(rdy[0]), 1);
    check("rst out_data", od[0], NOP0);
    check("rst occupancy", 32'(occ[0]), 0);
    check("rst bubble", 32'(bub0), 0);
    check("rst stall", 32'(stl0), 0);
    rst = 0;
    // back-pressure then drain
    iv[0] = 1; id[0] = 32'h11; step;
    id[0] = 32'h22; step;
    check("t1 in_ready full", 32'(rdy[0]), 0);
    check("t1 occupancy", 32'(occ[0]), 2);
    id[0] = 32'h33; step;
    check("t1 stall_cnt", 32'(stl0), 1);
    check("t1 head 11", od[0], 32'h11);
    ordy[0] = 1; step;
    check("t1 head 22", od[0], 32'h22);
    check("t1 ready after pop", 32'(rdy[0]), 1);
    step;
    check("t1 head 33", od[0], 32'h33);
    check("t1 occ after 33", 32'(occ[0]), 1);
    iv[0] = 0; step;
    check("t1 drained", 32'(ov[0]), 0);
    // bubbles while empty, then no-bypass push
    ordy[0] = 0; sc[0] = 1; step;
    sc[0] = 0;
    check("t2 clr bubble", 32'(bub0), 0);
    ordy[0] = 1;
    repeat (5) step;
    check("t2 bubble 5", 32'(bub0), 5);
    check("t2 nop data", od[0], NOP0);
    ordy[0] = 0; iv[0] = 1; id[0] = 32'hAB;
    check("t2 no bypass", od[0], NOP0);
    step;
    iv[0] = 0;
    check("t2 ab valid", 32'(ov[0]), 1);
    check("t2 ab data", od[0], 32'hAB);
    ordy[0] = 1; step;
    ordy[0] = 0;
    // flush of a full buffer with simultaneous push/pop
    iv[0] = 1; id[0] = 32'h01; step;
    id[0] = 32'h02; step;
    b = bub0; s = stl0;
    fl[0] = 1; id[0] = 32'h03; ordy[0] = 1; step;
    fl[0] = 0; iv[0] = 0; ordy[0] = 0;
    check("t3 occ", 32'(occ[0]), 0);
    check("t3 valid", 32'(ov[0]), 0);
    check("t3 nop", od[0], NOP0);
    check("t3 stall+1", 32'(stl0), 32'(s + 1));
    check("t3 bubble same", 32'(bub0), 32'(b));
    step;
    check("t3 03 dropped", 32'(ov[0]), 0);
    // DEPTH=3 wrap-around stream
    nxt = 0; tog = 1;
    for (int c = 0; c < 200 && got.size() < 10; c++) begin
      ordy[1] = tog; tog = !tog;
      iv[1] = nxt < 10; id[1] = 32'(nxt);
      acc = iv[1] && rdy[1];
      if (ov[1] && ordy[1]) got.push_back(int'(od[1]));
      step;
      if (acc) nxt++;
    end
    iv[1] = 0; ordy[1] = 0;
    check("t4 count", 32'(got.size()), 10);
    foreach (got[i]) check("t4 order", 32'(got[i]), 32'(i));
    // saturation with a 4-bit counter
    sc[1] = 1; step;
    sc[1] = 0; ordy[1] = 1;
    repeat (20) step;
    check("t5 bubble sat", 32'(bub1), 15);
    sc[1] = 1; step;
    sc[1] = 0; ordy[1] = 0;
    check("t5 bubble clr", 32'(bub1), 0);
    // randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(iv[k] && !rdy[k])) begin
          iv[k] = 1'($urandom_range(0, 1));
          id[k] = $urandom;
        end
        ordy[k] = $urandom_range(0, 3) != 0;
        fl[k]   = $urandom_range(0, 15) == 0;
        sc[k]   = $urandom_range(0, 31) == 0;
      end
      step;
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; fl[k] = 0; sc[k] = 0; ordy[k] = 0;
    end
    step;
    // asynchronous reset in mid-cycle while two entries are held
    iv[0] = 1; id[0] = 32'h71; step;
    id[0] = 32'h72; step;
    iv[0] = 0;
    check("t7 occ before", 32'(occ[0]), 2);
    #2;
    rst = 1;
    #1;
    check("t7 async valid", 32'(ov[0]), 0);
    check("t7 async ready", 32'(rdy[0]), 1);
    check("t7 async nop", od[0], NOP0);
    check("t7 async occ", 32'(occ[0]), 0);
    check("t7 async stall", 32'(stl0), 0);
    @(posedge clk);
    #1;
    rst = 0;
    iv[0] = 1; id[0] = 32'h55; step;
    iv[0] = 0;
    check("t7 resume valid", 32'(ov[0]), 1);
    check("t7 resume data", od[0], 32'h55);
    ordy[0] = 1; step;
    ordy[0] = 0;
    check("t7 resume drained", 32'(ov[0]), 0);
    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
